// File: rtl/sprite_shift_ctrl_pkg.sv
// Shared types and sizing for the sprite row path: FSM states and row geometry.
package sprite_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    WAIT_X,
    SHIFT
  } state_t;

  localparam int SPRITE_W = 16;
  localparam int SPRITE_H = 16;
  localparam int PIX_BITS = 3;
  localparam int ROW_BITS = SPRITE_W * PIX_BITS;

endpackage

// File: rtl/sprite_shift_ctrl_if.sv
// Video-timing side <-> sprite row controller bundle; master is the timing/ROM side.
interface sprite_shift_ctrl_if #(
  parameter int ROM_AW = 8
);
  import sprite_pkg::*;

  logic              line_start;
  logic              pix_tick;
  logic [9:0]        hcount;
  logic [9:0]        vcount;
  logic              sprite_on;
  logic [9:0]        sprite_x;
  logic [9:0]        sprite_y;
  logic [ROM_AW-1:0] rom_base;
  logic [ROM_AW-1:0] rom_addr;
  logic              rom_rd;
  logic              sh_ld;
  logic              sh_en;
  logic              pix_valid;
  logic              busy;

  modport master (
    output line_start, pix_tick, hcount, vcount, sprite_on, sprite_x, sprite_y, rom_base,
    input  rom_addr, rom_rd, sh_ld, sh_en, pix_valid, busy
  );

  modport slave (
    input  line_start, pix_tick, hcount, vcount, sprite_on, sprite_x, sprite_y, rom_base,
    output rom_addr, rom_rd, sh_ld, sh_en, pix_valid, busy
  );

endinterface

// File: rtl/sprite_shift_ctrl.sv
// Per-scanline sequencer: vertical hit test and row fetch at line start, one shifter
// load, then SPRITE_W shift enables starting at the tick whose column equals sprite_x.
module sprite_shift_ctrl #(
  parameter int SPRITE_W = sprite_pkg::SPRITE_W,
  parameter int SPRITE_H = sprite_pkg::SPRITE_H,
  parameter int ROM_AW   = 8,
  parameter int ROM_LAT  = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  sprite_shift_ctrl_if.slave  bus
);
  import sprite_pkg::*;

  localparam int CW = $clog2(SPRITE_W + 1);
  localparam int LW = $clog2(ROM_LAT + 2);

  state_t            state, state_nxt;
  logic [9:0]        x_q;
  logic [CW-1:0]     cnt;
  logic [LW-1:0]     wcnt;
  logic [ROM_AW-1:0] rom_addr_q;
  logic              rom_rd_q;
  logic              pix_valid_q;
  logic              sh_ld_c;
  logic              sh_en_c;
  logic [10:0]       y_end;
  logic              qualify;
  logic              launch;

  // 11-bit bottom bound so sprite_y near 1023 cannot wrap into a false hit
  assign y_end   = {1'b0, bus.sprite_y} + 11'(SPRITE_H);
  assign qualify = bus.sprite_on && (bus.vcount >= bus.sprite_y) && ({1'b0, bus.vcount} < y_end);
  assign launch  = bus.line_start && qualify;

  always_comb begin
    state_nxt = state;
    sh_ld_c   = 1'b0;
    sh_en_c   = 1'b0;
    // line_start wins from any state: abort and re-evaluate as a fresh line
    if (bus.line_start) begin
      state_nxt = qualify ? FETCH : IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        FETCH: begin
          if (wcnt == LW'(ROM_LAT)) state_nxt = LOAD;
        end
        LOAD: begin
          sh_ld_c   = 1'b1;
          state_nxt = WAIT_X;
        end
        WAIT_X: begin
          if (bus.pix_tick && (bus.hcount == x_q)) begin
            sh_en_c   = 1'b1;
            state_nxt = SHIFT;
          end
        end
        SHIFT: begin
          if (bus.pix_tick) begin
            sh_en_c = 1'b1;
            if (cnt == CW'(SPRITE_W - 1)) state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      x_q         <= '0;
      cnt         <= '0;
      wcnt        <= '0;
      rom_addr_q  <= '0;
      rom_rd_q    <= 1'b0;
      pix_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      rom_rd_q    <= launch;
      pix_valid_q <= sh_en_c;
      if (launch) begin
        x_q        <= bus.sprite_x;
        rom_addr_q <= bus.rom_base + ROM_AW'(bus.vcount - bus.sprite_y);
        wcnt       <= '0;
      end else if (state == FETCH) begin
        wcnt <= wcnt + LW'(1);
      end
      if (sh_en_c) cnt <= (state == WAIT_X) ? CW'(1) : cnt + CW'(1);
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.rom_rd    = rom_rd_q;
  assign bus.sh_ld     = sh_ld_c;
  assign bus.sh_en     = sh_en_c;
  assign bus.pix_valid = pix_valid_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_sprite_shift_ctrl.sv
// Scanline-level bench: drives whole lines and compares observed strobes with a line model.
module tb_sprite_shift_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sprite_shift_ctrl_if #(.ROM_AW(8)) bus ();

  sprite_shift_ctrl #(
    .SPRITE_W(16), .SPRITE_H(16), .ROM_AW(8), .ROM_LAT(1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int t_ls;
  int rd_cyc[$];
  int rd_addr[$];
  int ld_cyc[$];
  int ld_addr[$];
  int en_cyc[$];
  int pv_cyc[$];
  int tick_cyc[640];
  int overlap;
  bit busy_seen;
  bit busy_ls;

  task automatic clear_rec();
    rd_cyc.delete(); rd_addr.delete(); ld_cyc.delete(); ld_addr.delete();
    en_cyc.delete(); pv_cyc.delete();
    overlap = 0; busy_seen = 0; busy_ls = 0;
  endtask

  task automatic cycle();
    @(negedge clk);
    if (bus.rom_rd) begin rd_cyc.push_back(cyc); rd_addr.push_back(int'(bus.rom_addr)); end
    if (bus.sh_ld) begin ld_cyc.push_back(cyc); ld_addr.push_back(int'(bus.rom_addr)); end
    if (bus.sh_en) en_cyc.push_back(cyc);
    if (bus.pix_valid) pv_cyc.push_back(cyc);
    if (bus.sh_ld && bus.sh_en) overlap++;
    if (bus.busy) busy_seen = 1;
    if (bus.line_start && bus.busy) busy_ls = 1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_line(input int vc, input int sx, input int sy, input bit on,
                          input int base, input int period, input bit scramble);
    bus.vcount = 10'(vc); bus.sprite_x = 10'(sx); bus.sprite_y = 10'(sy);
    bus.sprite_on = on; bus.rom_base = 8'(base); bus.hcount = '0; bus.pix_tick = 0;
    clear_rec();
    bus.line_start = 1; t_ls = cyc; cycle(); bus.line_start = 0;
    if (scramble) bus.sprite_x = 10'($urandom_range(0, 1023));
    repeat (5) cycle();
    for (int c = 0; c < 640; c++) begin
      bus.hcount = 10'(c); bus.pix_tick = 1; tick_cyc[c] = cyc; cycle(); bus.pix_tick = 0;
      for (int p = 1; p < period; p++) cycle();
    end
    repeat (3) cycle();
  endtask

  // Line-level model: does the sprite hit this line, which row, how many pixels fit.
  function automatic void model(input int vc, input int sy, input int sx, input bit on,
                                input int base, output bit q, output int addr, output int n);
    q    = on && (vc >= sy) && (vc < sy + 16);
    addr = (base + vc - sy) & 255;
    if (!q || sx >= 640) n = 0;
    else n = (640 - sx < 16) ? 640 - sx : 16;
  endfunction

  function automatic bit en_aligned(input int x);
    for (int k = 0; k < en_cyc.size(); k++) begin
      if (x + k > 639) return 0;
      if (en_cyc[k] != tick_cyc[x + k]) return 0;
    end
    return 1;
  endfunction

  function automatic bit pv_aligned();
    if (pv_cyc.size() != en_cyc.size()) return 0;
    for (int k = 0; k < en_cyc.size(); k++) if (pv_cyc[k] != en_cyc[k] + 1) return 0;
    return 1;
  endfunction

  function automatic int first_at(input int q[$]);
    return (q.size() > 0) ? q[0] - t_ls : -1;
  endfunction

  task automatic test_reset();
    tests++;
    if ({bus.rom_rd, bus.sh_ld, bus.sh_en, bus.pix_valid, bus.busy} !== 5'b0) begin
      fails++; $display("FAIL reset_strobes: got %b expected 00000",
                        {bus.rom_rd, bus.sh_ld, bus.sh_en, bus.pix_valid, bus.busy});
    end
    tests++;
    if (bus.rom_addr !== 8'h00) begin
      fails++; $display("FAIL reset_rom_addr: got %h expected 00", bus.rom_addr);
    end
  endtask

  task automatic test_basic();
    run_line(103, 200, 100, 1, 'h40, 1, 0);
    tests++; if (rd_cyc.size() !== 1) begin fails++; $display("FAIL basic_rd_count: got %0d expected 1", rd_cyc.size()); end
    tests++; if (first_at(rd_cyc) !== 1) begin fails++; $display("FAIL basic_rd_time: got %0d expected 1", first_at(rd_cyc)); end
    tests++; if (rd_addr.size() == 0 || rd_addr[0] !== 'h43) begin fails++; $display("FAIL basic_addr: got %0d expected %0d", rd_addr.size() ? rd_addr[0] : -1, 'h43); end
    tests++; if (ld_cyc.size() !== 1) begin fails++; $display("FAIL basic_ld_count: got %0d expected 1", ld_cyc.size()); end
    tests++; if (first_at(ld_cyc) !== 3) begin fails++; $display("FAIL basic_ld_time: got %0d expected 3", first_at(ld_cyc)); end
    tests++; if (ld_addr.size() == 0 || ld_addr[0] !== 'h43) begin fails++; $display("FAIL basic_addr_stable: got %0d expected %0d", ld_addr.size() ? ld_addr[0] : -1, 'h43); end
    tests++; if (en_cyc.size() !== 16) begin fails++; $display("FAIL basic_en_count: got %0d expected 16", en_cyc.size()); end
    tests++; if (en_aligned(200) !== 1'b1) begin fails++; $display("FAIL basic_en_columns: got %0d expected 1", en_aligned(200)); end
    tests++; if (pv_aligned() !== 1'b1) begin fails++; $display("FAIL basic_pix_valid: got %0d pulses expected 16 one clk after each en", pv_cyc.size()); end
  endtask

  task automatic test_vbounds();
    int vcs[3] = '{99, 115, 116};
    bit q; int addr; int n;
    foreach (vcs[i]) begin
      model(vcs[i], 100, 200, 1, 'h40, q, addr, n);
      run_line(vcs[i], 200, 100, 1, 'h40, 1, 0);
      tests++; if (rd_cyc.size() !== int'(q)) begin fails++; $display("FAIL vbound_rd vc=%0d: got %0d expected %0d", vcs[i], rd_cyc.size(), q); end
      if (q) begin
        tests++; if (rd_addr[0] !== addr) begin fails++; $display("FAIL vbound_addr vc=%0d: got %0d expected %0d", vcs[i], rd_addr[0], addr); end
      end
      tests++; if (en_cyc.size() !== n) begin fails++; $display("FAIL vbound_en vc=%0d: got %0d expected %0d", vcs[i], en_cyc.size(), n); end
    end
  endtask

  task automatic test_sprite_off();
    run_line(105, 200, 100, 0, 'h40, 1, 0);
    tests++; if (busy_seen !== 1'b0) begin fails++; $display("FAIL off_busy: got %0d expected 0", busy_seen); end
    tests++; if (ld_cyc.size() + en_cyc.size() !== 0) begin fails++; $display("FAIL off_activity: got %0d expected 0", ld_cyc.size() + en_cyc.size()); end
  endtask

  task automatic test_abort();
    run_line(104, 630, 100, 1, 'h40, 1, 0);
    tests++; if (en_cyc.size() !== 10) begin fails++; $display("FAIL abort_en_count: got %0d expected 10", en_cyc.size()); end
    tests++; if (pv_cyc.size() !== 10) begin fails++; $display("FAIL abort_pv_count: got %0d expected 10", pv_cyc.size()); end
    run_line(101, 200, 100, 1, 'h40, 1, 0);
    tests++; if (busy_ls !== 1'b1) begin fails++; $display("FAIL abort_busy_at_line_start: got %0d expected 1", busy_ls); end
    tests++; if (first_at(rd_cyc) !== 1 || rd_addr[0] !== 'h41) begin fails++; $display("FAIL abort_refetch: got time %0d expected 1 addr 65", first_at(rd_cyc)); end
    tests++; if (en_cyc.size() !== 16 || en_aligned(200) !== 1'b1) begin fails++; $display("FAIL abort_next_line_en: got %0d expected 16", en_cyc.size()); end
  endtask

  task automatic test_reset_mid();
    bit done = 0;
    int c = 0;
    bus.vcount = 10'd105; bus.sprite_x = 10'd20; bus.sprite_y = 10'd100;
    bus.sprite_on = 1; bus.rom_base = 8'h10;
    clear_rec();
    bus.line_start = 1; cycle(); bus.line_start = 0;
    repeat (5) cycle();
    while (c < 640 && !done) begin
      bus.hcount = 10'(c); bus.pix_tick = 1; cycle(); bus.pix_tick = 0;
      c++;
      if (en_cyc.size() == 5) done = 1;
    end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL rmid_reach5: got %0d expected 5", en_cyc.size()); end
    bus.hcount = 10'(c); bus.pix_tick = 1;
    reset_n = 0;
    #1;
    tests++;
    if ({bus.rom_rd, bus.sh_ld, bus.sh_en, bus.pix_valid, bus.busy} !== 5'b0 || bus.rom_addr !== 8'h00) begin
      fails++; $display("FAIL rmid_outputs: got %b addr %h expected 00000 addr 00",
                        {bus.rom_rd, bus.sh_ld, bus.sh_en, bus.pix_valid, bus.busy}, bus.rom_addr);
    end
    clear_rec();
    for (int k = 0; k < 60; k++) begin
      if (k == 4) reset_n = 1;
      bus.hcount = 10'(c + k); bus.pix_tick = 1; cycle();
    end
    bus.pix_tick = 0;
    tests++; if (rd_cyc.size() + ld_cyc.size() + en_cyc.size() !== 0) begin fails++; $display("FAIL rmid_quiet: got %0d expected 0", rd_cyc.size() + ld_cyc.size() + en_cyc.size()); end
    run_line(105, 20, 100, 1, 'h10, 1, 0);
    tests++; if (en_cyc.size() !== 16 || en_aligned(20) !== 1'b1) begin fails++; $display("FAIL rmid_resume: got %0d expected 16", en_cyc.size()); end
    tests++; if (rd_addr.size() == 0 || rd_addr[0] !== 'h15) begin fails++; $display("FAIL rmid_addr: got %0d expected %0d", rd_addr.size() ? rd_addr[0] : -1, 'h15); end
  endtask

  task automatic test_tick_rate();
    int periods[2] = '{2, 1};
    foreach (periods[i]) begin
      run_line(110, 300, 100, 1, 'h20, periods[i], 0);
      tests++; if (en_cyc.size() !== 16) begin fails++; $display("FAIL rate%0d_en_count: got %0d expected 16", periods[i], en_cyc.size()); end
      tests++; if (overlap !== 0) begin fails++; $display("FAIL rate%0d_overlap: got %0d expected 0", periods[i], overlap); end
      tests++; if (en_aligned(300) !== 1'b1) begin fails++; $display("FAIL rate%0d_columns: got %0d expected 1", periods[i], en_aligned(300)); end
      tests++; if (pv_aligned() !== 1'b1) begin fails++; $display("FAIL rate%0d_pix_valid: got %0d pulses expected 16 one clk after en", periods[i], pv_cyc.size()); end
    end
  endtask

  task automatic test_random();
    bit q; int addr; int n;
    for (int it = 0; it < 12; it++) begin
      int sy = $urandom_range(0, 400);
      int vc = sy + $urandom_range(0, 24) - 4;
      int sx = $urandom_range(0, 660);
      bit on = ($urandom_range(0, 3) != 0);
      int base = $urandom_range(0, 255);
      int per = $urandom_range(1, 2);
      if (vc < 0) vc = 0;
      model(vc, sy, sx, on, base, q, addr, n);
      run_line(vc, sx, sy, on, base, per, 1);
      tests++; if (rd_cyc.size() !== int'(q) || ld_cyc.size() !== int'(q)) begin fails++; $display("FAIL rand%0d_fetch: got rd %0d ld %0d expected %0d", it, rd_cyc.size(), ld_cyc.size(), q); end
      if (q) begin
        tests++; if (rd_addr[0] !== addr) begin fails++; $display("FAIL rand%0d_addr: got %0d expected %0d", it, rd_addr[0], addr); end
      end
      tests++; if (en_cyc.size() !== n || en_aligned(sx) !== 1'b1) begin fails++; $display("FAIL rand%0d_en: got %0d expected %0d at x=%0d", it, en_cyc.size(), n, sx); end
      tests++; if (pv_aligned() !== 1'b1 || overlap !== 0) begin fails++; $display("FAIL rand%0d_pv: got %0d pulses overlap %0d expected %0d overlap 0", it, pv_cyc.size(), overlap, n); end
    end
  endtask

  initial begin
    reset_n = 0;
    bus.line_start = 0; bus.pix_tick = 0; bus.hcount = '0; bus.vcount = '0;
    bus.sprite_on = 0; bus.sprite_x = '0; bus.sprite_y = '0; bus.rom_base = '0;
    #2;
    test_reset();
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1;
    cycle();
    test_basic();
    test_vbounds();
    test_sprite_off();
    test_abort();
    test_reset_mid();
    test_tick_rate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sprite_shift_ctrl.md
# sprite_shift_ctrl

Per-scanline sequencer for the 16-pixel × 3-bit sprite row shifter in the VGA sprite path. At each line start it decides whether the sprite covers the current line and, if so, fetches that sprite row from sprite ROM. It then pulses the shifter's load, and issues 16 shift enables aligned to the sprite's horizontal position. It also produces a pixel-valid strobe so the palette and mixer stage knows when the shifter output is a live sprite pixel.

## Interface
Parameters:
- SPRITE_W, 16, pixels per row; must equal the shifter depth.
- SPRITE_H, 16, rows per sprite.
- ROM_AW, 8, sprite ROM address width.
- ROM_LAT, 1, cycles from rom_rd to valid ROM data at the shifter data_in.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- line_start  in  1  one-cycle pulse in horizontal blanking, at least ROM_LAT+3 cycles before column 0.
- pix_tick  in  1  one cycle per displayed pixel.
- hcount  in  10  current pixel column, valid on pix_tick.
- vcount  in  10  current line.
- sprite_on  in  1  sprite enabled.
- sprite_x  in  10  left column.
- sprite_y  in  10  top line.
- rom_base  in  ROM_AW  ROM address of sprite row 0.
- rom_addr  out  ROM_AW  registered row address.
- rom_rd  out  1  one-cycle read strobe.
- sh_ld  out  1  shifter load.
- sh_en  out  1  shifter shift enable.
- pix_valid  out  1  the shifter data_out holds a sprite pixel this cycle.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, FETCH, LOAD, WAIT_X, SHIFT.
- IDLE → FETCH on line_start when all of the following hold:
  - sprite_on=1;
  - vcount ≥ sprite_y;
  - vcount < sprite_y+SPRITE_H, compared at 11 bits so the sum cannot wrap.
- On that transition:
  - latch x_q ← sprite_x;
  - rom_addr ← rom_base + (vcount − sprite_y), truncated to ROM_AW;
  - rom_rd=1 for one cycle.
- FETCH: wait ROM_LAT cycles, then go to LOAD.
- LOAD: sh_ld=1 for exactly one cycle, then go to WAIT_X.
- WAIT_X: on pix_tick with hcount==x_q, assert sh_en in the same cycle (combinational), set cnt=1, go to SHIFT.
- SHIFT: sh_en = pix_tick. Each enabled cycle increments cnt. The enable on which cnt reaches SPRITE_W is the last one, and the FSM returns to IDLE.
- sh_ld and sh_en are never both high; the shifter gives ld priority, but the controller must not depend on that.
- pix_valid is sh_en registered by one clk, which matches the shifter's registered data_out.
  - Pixel k (data_in bits [3k+2:3k], k=0 first) is valid in the cycle after the k-th enable.
  - That pixel belongs to column x_q+k.
- line_start in any non-IDLE state aborts to IDLE and is re-evaluated in that same cycle as a fresh IDLE line_start. Abort occurs when the sprite runs past the line end or the column was missed.
- If WAIT_X never sees a match (for example x_q beyond the last column), the FSM stays in WAIT_X until the next line_start. No enables are issued for that line.
- sprite_x changing after line_start has no effect until the next line, because x_q is latched at line_start.

## Timing
- Reset (asynchronous, reset_n=0) clears every output and internal register:
  - state = IDLE;
  - rom_addr = 0;
  - rom_rd = sh_ld = sh_en = pix_valid = busy = 0;
  - cnt = 0.
- Reset mid-operation takes effect immediately. No further ld or en is issued until the next qualifying line_start after reset is released.
- Cycle-level sequence, with line_start at cycle t:
  - rom_rd at t+1 (registered);
  - sh_ld at t+1+ROM_LAT+1, i.e. t+3 with the default;
  - WAIT_X from the following cycle.
- rom_addr is stable from t+1 until LOAD completes.
- Pixel latency: pix_valid rises 1 clk after each sh_en.

## Structure
- Package sprite_pkg holds:
  - the state enum (IDLE, FETCH, LOAD, WAIT_X, SHIFT);
  - the SPRITE_W, SPRITE_H and PIX_BITS (3) constants;
  - the derived constant ROW_BITS = SPRITE_W·PIX_BITS = 48.
- The controller is a single module. The integration wrapper sprite_row_unit instantiates sprite_shift_ctrl, the ROM and the shift register side by side.

## Test plan
- Basic draw: sprite_y=100, vcount=103, sprite_x=200, rom_base=0x40 → expected response:
  - rom_addr=0x43 with one rom_rd;
  - one sh_ld;
  - 16 sh_en on ticks at hcount 200..215;
  - 16 pix_valid pulses carrying pixels 0..15 in order.
- Vertical bounds:
  - vcount=99 → no rom_rd;
  - vcount=115 → row 15 fetched (addr 0x4F);
  - vcount=116 → no activity.
- sprite_on=0 with an in-range vcount → busy stays 0, and no ld or en is issued.
- Abort: sprite_x=630, with line_start arriving after 10 enables → FSM goes to IDLE, then a new fetch starts in the same cycle. At most 10 pix_valid pulses occur on the aborted line.
- Reset mid-SHIFT after 5 enables → all outputs are 0 immediately. The FSM resumes normally on the next qualifying line_start.
- pix_tick every 2nd clk versus every clk → in both cases exactly 16 sh_en are issued, sh_en and sh_ld never overlap, and each pix_valid occurs exactly 1 clk after its sh_en.
